// File: rtl/vga_row_pattern_gen.sv
// ============================================================================
//  Module      : vga_row_pattern_gen
//  Description : Parametrised VGA timing generator with a row-banded colour
//                pattern engine. Every 2**BAND_LOG2 lines form a band whose
//                palette index is (band + scroll). A frame-latched mode
//                selects solid bands, a checker overlay, scrolling bands or
//                blank video.
//
//  Ports
//    clk         in   pixel-domain clock
//    rst         in   asynchronous, active-high reset
//    ena         in   pixel enable; all state advances only when 1
//    mode        in   [1:0] pattern mode, taken at the frame boundary
//    r, g, b     out  [COLOR_W-1:0] pixel colour, r in the MSBs of the pixel
//    hsync       out  horizontal sync, asserted level SYNC_POL
//    vsync       out  vertical sync, asserted level SYNC_POL
//    active      out  visible-region flag
//    hpos        out  [clog2(H_TOTAL)-1:0] column of the presented pixel
//    vpos        out  [clog2(V_TOTAL)-1:0] line of the presented pixel
//    frame_tick  out  high while the presented pixel is the last of a frame
//    line_tick   out  high while the presented pixel is the last of a line
//
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_row_pattern_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned COLOR_W   = 2,
    parameter int unsigned BAND_LOG2 = 4,
    parameter bit          SYNC_POL  = 1'b0,
    localparam int unsigned PIX_W    = 3 * COLOR_W,
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW       = $clog2(H_TOTAL),
    localparam int unsigned VW       = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [1:0]         mode,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [HW-1:0]      hpos,
    output logic [VW-1:0]      vpos,
    output logic               frame_tick,
    output logic               line_tick
);

    // ------------------------------------------------------------------------
    // Timing constants, sized to the counters they are compared against.
    // ------------------------------------------------------------------------
    localparam logic [HW-1:0] c_h_last     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] c_h_active   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] c_hs_start   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] c_hs_end     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] c_v_last     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] c_v_active   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] c_vs_start   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] c_vs_end     = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [1:0]    c_mode_solid  = 2'd0;
    localparam logic [1:0]    c_mode_check  = 2'd1;
    localparam logic [1:0]    c_mode_scroll = 2'd2;
    localparam logic [1:0]    c_mode_blank  = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [HW-1:0]    r_hcnt;
    logic [VW-1:0]    r_vcnt;
    logic [1:0]       r_mode_q;
    logic [PIX_W-1:0] r_scroll;

    // ------------------------------------------------------------------------
    // Decode of the current counter position
    // ------------------------------------------------------------------------
    logic             w_h_last;
    logic             w_v_last;
    logic             w_frame_last;
    logic             w_active;
    logic             w_hs_on;
    logic             w_vs_on;
    logic [PIX_W-1:0] w_band;
    logic [PIX_W-1:0] w_col;
    logic [PIX_W-1:0] w_idx;
    logic [PIX_W-1:0] w_pix;

    assign w_h_last     = (r_hcnt == c_h_last);
    assign w_v_last     = (r_vcnt == c_v_last);
    assign w_frame_last = w_h_last && w_v_last;

    assign w_active = (r_hcnt < c_h_active) && (r_vcnt < c_v_active);
    assign w_hs_on  = (r_hcnt >= c_hs_start) && (r_hcnt < c_hs_end);
    assign w_vs_on  = (r_vcnt >= c_vs_start) && (r_vcnt < c_vs_end);

    // Band and column numbers are only ever used modulo 2**PIX_W, so they are
    // truncated (or zero-extended) straight to the palette width.
    assign w_band = PIX_W'(r_vcnt >> BAND_LOG2);
    assign w_col  = PIX_W'(r_hcnt >> BAND_LOG2);
    assign w_idx  = w_band + r_scroll;

    always_comb begin
        w_pix = '0;
        if (w_active) begin
            case (r_mode_q)
                c_mode_solid:  w_pix = w_idx;
                c_mode_check:  w_pix = w_idx ^ w_col;
                c_mode_scroll: w_pix = w_idx;
                c_mode_blank:  w_pix = '0;
                default:       w_pix = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (ena) begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + VW'(1);
            end else begin
                r_hcnt <= r_hcnt + HW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame-boundary state. Both updates happen on the same enabled edge that
    // registers frame_tick, so the new mode and scroll are seen first by the
    // pixel (0,0) computation on the next enabled edge. The scroll decision
    // uses the mode that was live for the frame just ending.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_q <= c_mode_solid;
            r_scroll <= '0;
        end else if (ena && w_frame_last) begin
            r_mode_q <= mode;
            if (r_mode_q == c_mode_scroll) begin
                r_scroll <= r_scroll + PIX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output registers: everything is a one-cycle-delayed image of the
    // counter state, so all outputs share the same alignment to hpos/vpos.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r          <= '0;
            g          <= '0;
            b          <= '0;
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            active     <= 1'b0;
            hpos       <= '0;
            vpos       <= '0;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else if (ena) begin
            r          <= w_pix[PIX_W-1 -: COLOR_W];
            g          <= w_pix[2*COLOR_W-1 -: COLOR_W];
            b          <= w_pix[COLOR_W-1:0];
            hsync      <= w_hs_on ? SYNC_POL : ~SYNC_POL;
            vsync      <= w_vs_on ? SYNC_POL : ~SYNC_POL;
            active     <= w_active;
            hpos       <= r_hcnt;
            vpos       <= r_vcnt;
            line_tick  <= w_h_last;
            frame_tick <= w_frame_last;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_row_pattern_gen.sv
// ============================================================================
//  Module      : tb_vga_row_pattern_gen
//  Description : Directed self-checking bench for vga_row_pattern_gen using a
//                shrunken raster (24 x 16 total, 16 x 12 visible, bands of
//                4 lines) so that many frames fit in a short run.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_row_pattern_gen;

    // Raster: H 16+2+3+3 = 24, V 12+1+2+1 = 16, frame = 384 pixels.
    logic       clk;
    logic       rst;
    logic       ena;
    logic [1:0] mode;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic [4:0] hpos;
    logic [3:0] vpos;
    logic       frame_tick;
    logic       line_tick;
    logic [5:0] rgb;

    int n_tests = 0;
    int n_fail  = 0;

    assign rgb = {r, g, b};

    vga_row_pattern_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (12), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .COLOR_W  (2),  .BAND_LOG2 (2), .SYNC_POL (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .mode       (mode),
        .r          (r),
        .g          (g),
        .b          (b),
        .hsync      (hsync),
        .vsync      (vsync),
        .active     (active),
        .hpos       (hpos),
        .vpos       (vpos),
        .frame_tick (frame_tick),
        .line_tick  (line_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Advance (at negedges) until the presented pixel is (h,v); bounded.
    task automatic wait_pos(input int h, input int v);
        int n;
        n = 0;
        while (!(int'(hpos) == h && int'(vpos) == v) && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) check_eq("wait_pos_timeout", {hpos, vpos}, 32'(h * 16 + v));
    endtask

    initial begin
        int cnt;
        int hs_low;
        int vs_low;
        int lt_cnt;

        rst  = 1'b1;
        ena  = 1'b0;
        mode = 2'd0;

        // ---------------- reset state ----------------
        #1;
        check_eq("rst_hsync", hsync, 1);
        check_eq("rst_vsync", vsync, 1);
        check_eq("rst_rgb", rgb, 0);
        check_eq("rst_active", active, 0);
        check_eq("rst_hpos", hpos, 0);
        check_eq("rst_vpos", vpos, 0);
        check_eq("rst_ticks", {frame_tick, line_tick}, 0);
        tick();
        tick();
        rst = 1'b0;
        ena = 1'b1;

        // ---------------- frame 0, mode 0 bands ----------------
        tick();
        check_eq("first_hpos", hpos, 0);
        check_eq("first_vpos", vpos, 0);
        check_eq("first_active", active, 1);
        check_eq("first_rgb", rgb, 6'h00);
        wait_pos(0, 4);  check_eq("m0_band1", rgb, 6'h01);
        wait_pos(17, 4); check_eq("hs_17", hsync, 1);
        wait_pos(18, 4); check_eq("hs_18", hsync, 0);
        wait_pos(20, 4); check_eq("hs_20", hsync, 0);
        wait_pos(21, 4); check_eq("hs_21", hsync, 1);
        wait_pos(22, 4); check_eq("lt_22", line_tick, 0);
        wait_pos(23, 4); check_eq("lt_23", line_tick, 1);
        wait_pos(16, 5); check_eq("blank_h_rgb", rgb, 0);
        check_eq("blank_h_active", active, 0);
        wait_pos(0, 6);  mode = 2'd3;           // mid-frame change
        wait_pos(0, 8);  check_eq("m0_band2_after_change", rgb, 6'h02);
        wait_pos(0, 11); check_eq("m0_last_line", rgb, 6'h02);
        wait_pos(0, 12); check_eq("blank_v_active", active, 0);
        check_eq("vs_12", vsync, 1);
        wait_pos(0, 13); check_eq("vs_13", vsync, 0);
        wait_pos(0, 14); check_eq("vs_14", vsync, 0);
        wait_pos(0, 15); check_eq("vs_15", vsync, 1);
        wait_pos(22, 15); check_eq("ft_22", frame_tick, 0);
        wait_pos(23, 15); check_eq("ft_23", frame_tick, 1);
        check_eq("lt_frame_end", line_tick, 1);

        // ---------------- frame 1, mode 3 blank ----------------
        wait_pos(5, 4);  check_eq("m3_rgb", rgb, 0);
        check_eq("m3_active", active, 1);
        wait_pos(18, 4); check_eq("m3_hsync", hsync, 0);
        wait_pos(0, 13); check_eq("m3_vsync", vsync, 0);
        wait_pos(0, 14); mode = 2'd1;

        // ---------------- frame 2, mode 1 checker ----------------
        wait_pos(4, 0);  check_eq("m1_b0_c1", rgb, 6'h01);
        wait_pos(8, 4);  check_eq("m1_b1_c2", rgb, 6'h03);
        wait_pos(12, 8); check_eq("m1_b2_c3", rgb, 6'h01);
        wait_pos(16, 8); check_eq("m1_blank", rgb, 0);
        wait_pos(0, 9);  mode = 2'd2;

        // ---------------- frames 3.., mode 2 scroll ----------------
        for (int k = 0; k < 70; k++) begin
            wait_pos(0, 0);
            check_eq("m2_line0", rgb, 32'(k % 64));
            if (k == 63) begin
                wait_pos(0, 4); check_eq("m2_wrap_band1", rgb, 6'h00);
                wait_pos(0, 8); check_eq("m2_wrap_band2", rgb, 6'h01);
            end
            tick();
        end

        // ---------------- async reset mid-frame, scroll = 5 ----------------
        wait_pos(10, 6); check_eq("pre_rst_rgb", rgb, 6'h06);
        #2 rst = 1'b1;
        #1;
        check_eq("async_hpos", hpos, 0);
        check_eq("async_vpos", vpos, 0);
        check_eq("async_rgb", rgb, 0);
        check_eq("async_active", active, 0);
        check_eq("async_sync", {hsync, vsync}, 2'b11);
        tick();
        rst = 1'b0;
        tick();
        check_eq("post_rst_pos", {hpos, vpos}, 0);
        check_eq("post_rst_rgb", rgb, 0);
        wait_pos(0, 4); check_eq("post_rst_band1", rgb, 6'h01);

        // ---------------- one full frame of sync statistics ----------------
        wait_pos(23, 15);
        cnt = 0; hs_low = 0; vs_low = 0; lt_cnt = 0;
        do begin
            tick();
            cnt++;
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if (line_tick) lt_cnt++;
        end while (!frame_tick && cnt < 1000);
        check_eq("frame_period", cnt, 384);
        check_eq("hsync_low_cycles", hs_low, 48);
        check_eq("vsync_low_cycles", vs_low, 48);
        check_eq("line_ticks", lt_cnt, 16);

        // ---------------- pixel enable 1,0,1,0 ----------------
        wait_pos(20, 15);
        ena = 1'b0; tick(); check_eq("ena_hold", hpos, 20);
        ena = 1'b1; tick(); check_eq("ena_adv", hpos, 21);
        ena = 1'b0; tick(); check_eq("ena_hold2", hpos, 21);
        ena = 1'b1; tick();
        ena = 1'b0; tick();
        ena = 1'b1; tick(); check_eq("ena_ft_on", frame_tick, 1);
        ena = 1'b0; tick(); check_eq("ena_ft_stretch", frame_tick, 1);
        check_eq("ena_ft_hpos", hpos, 23);
        ena = 1'b1; tick(); check_eq("ena_ft_off", frame_tick, 0);
        check_eq("ena_wrap_pos", {hpos, vpos}, 0);
        cnt = 0;
        do begin
            ena = ~ena;
            tick();
            cnt++;
        end while (!(hpos == 5'd0 && vpos == 4'd1) && cnt < 200);
        check_eq("ena_line_period", cnt, 48);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_row_pattern_gen.md
# vga_row_pattern_gen

Parametrised VGA timing generator with a row-banded colour pattern engine, the successor to the fixed row-by-row VGA tile. Produces hsync/vsync, active-video and pixel position from a pixel-rate enable. Fills each horizontal band of `2**BAND_LOG2` lines with a palette index derived from the band number, a per-frame scroll offset and a selectable mode. Sits directly behind the tile's pin mux and drives the RGB/sync output pins.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch and sync lengths in pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync lengths in lines
- `COLOR_W`, 2, bits per colour channel; `PIX_W = 3*COLOR_W`
- `BAND_LOG2`, 4, log2 of band height in lines; also log2 of column width in mode 1
- `SYNC_POL`, 0, asserted sync level (0 = active-low)

- `clk`  in  1  pixel-domain clock
- `rst`  in  1  asynchronous, active-high reset
- `ena`  in  1  pixel enable; counters and outputs advance only when 1
- `mode`  in  2  pattern mode; sampled at frame boundary
- `r`, `g`, `b`  out  COLOR_W each  pixel colour
- `hsync`, `vsync`  out  1  sync outputs at polarity SYNC_POL
- `active`  out  1  visible-region flag
- `hpos`  out  clog2(H_TOTAL)  current column
- `vpos`  out  clog2(V_TOTAL)  current line
- `frame_tick`  out  1  one-cycle pulse on the last pixel of a frame
- `line_tick`  out  1  one-cycle pulse on the last pixel of each line

## Operation
- `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP`; `V_TOTAL` is defined analogously.
- The `hcnt` counter runs 0..H_TOTAL-1 and increments on `ena`, wrapping to 0. `vcnt` increments when `hcnt` wraps and itself wraps at V_TOTAL-1.
- hsync is asserted for `H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC`. vsync uses the same rule on `vcnt`.
- `active` is 1 when `hcnt < H_ACTIVE` and `vcnt < V_ACTIVE`.
- `band = vcnt >> BAND_LOG2`. `col = hcnt >> BAND_LOG2`. `idx = (band + scroll)` mod `2**PIX_W`.
- Pixel value by mode:
  - Mode 0, solid bands: pixel = idx.
  - Mode 1, checker: pixel = idx XOR `col[PIX_W-1:0]`.
  - Mode 2, scrolling bands: pixel = idx; `scroll` increments by 1 (mod `2**PIX_W`) at every frame boundary while mode 2 is live.
  - Mode 3, blank: pixel = 0; syncs continue.
- Pixel mapping: `{r,g,b} = pixel[PIX_W-1:0]`, with r in the MSBs.
- Outside the active region, r/g/b are forced to 0 in every mode.
- `mode_q` latches `mode` on frame_tick and is the mode actually used. Mid-frame changes on `mode` have no effect until the next frame.
- `scroll` holds its value in modes 0, 1 and 3. It is not cleared by mode changes, only by `rst`.

## Timing
- All outputs are registered and reflect the counter state one cycle earlier. Output cycle N corresponds to (hpos, vpos) as presented at cycle N.
- hpos/vpos are the registered copies of `hcnt`/`vcnt`. r/g/b, sync and active are aligned to them, with no skew between any outputs.
- line_tick is 1 for exactly one cycle, on the cycle where hpos = H_TOTAL-1.
- frame_tick is 1 for exactly one cycle, where hpos = H_TOTAL-1 and vpos = V_TOTAL-1.
- The mode_q and scroll updates take effect from pixel (0,0) of the following frame.
- When `ena` = 0, all registers hold, including tick outputs. A tick that is high stays high until the next enabled cycle.
- While `rst` is asserted, and immediately on assertion:
  - counters, `scroll` and `mode_q` clear to 0;
  - hsync and vsync are driven to `~SYNC_POL`;
  - r/g/b, active, line_tick and frame_tick are 0;
  - hpos and vpos are 0.
- First enabled cycle after `rst` deasserts: outputs present pixel (0,0).
- Reset mid-frame aborts the frame. No partial scroll increment occurs.

## Test plan
- **Sync timing.** Defaults, `ena`=1 for two frames, then:
  - hsync is low for exactly 96 cycles, starting at hpos = 656, every 800 cycles;
  - vsync is low for 2 lines, starting at vpos = 490;
  - frame_tick occurs every 420000 cycles.
- **Mode 0 bands.** COLOR_W=2, BAND_LOG2=4, mode=0 from reset:
  - lines 0–15 output rgb = 6'h00;
  - lines 16–31 output 6'h01;
  - line 479 outputs 6'h1D;
  - hpos >= 640 outputs 0.
- **Mode 2 scroll.** Hold mode=2 for 65 frames:
  - line 0 colour is 0 in the first frame (mode latched at frame 0's end);
  - line 0 colour then increments by 1 per frame;
  - the colour wraps from 6'h3F to 6'h00.
- **Mode change mid-frame.** Switch mode 0→3 at vpos = 100: the current frame keeps bands, and the next frame is all black with sync unchanged.
- **Pixel enable.** `ena` toggles 1,0,1,0:
  - hpos advances once per two clocks;
  - an asserted frame_tick stretches to 2 clocks;
  - the line period becomes 1600 clocks.
- **Async reset.** Assert `rst` at hpos = 300, vpos = 200, in mode 2 with scroll = 5:
  - outputs go to their reset values within the same cycle, without waiting for a `clk` edge;
  - after release, the pixel (0,0) colour is 0.
